// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with runtime baud divisor,
// 3-sample majority voting, false-start rejection, optional parity and
// second stop bit, valid/ready holding register, overrun and break detection.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic                 rxd,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_perror,
    output logic                 rx_ferror,
    output logic                 rx_overrun,
    output logic                 rx_break,
    output logic                 rx_busy
);

    localparam int S_W = $clog2(OVERSAMPLE);
    localparam int B_W = $clog2(DATA_BITS);

    // Sample indices inside one bit period: two early samples, the decision
    // sample, and the last sample where the bit period wraps.
    localparam logic [S_W-1:0] S_A    = S_W'(OVERSAMPLE/2 - 1);
    localparam logic [S_W-1:0] S_B    = S_W'(OVERSAMPLE/2);
    localparam logic [S_W-1:0] S_D    = S_W'(OVERSAMPLE/2 + 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BREAK
    } state_t;

    state_t state, state_nxt;

    // Synchroniser flops for the asynchronous pin
    logic rxd_p0, rxd_p1;

    // Baud tick generation
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_lat;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 tick;

    // Bit sampling
    logic [S_W-1:0] s_cnt;
    logic [B_W-1:0] bit_cnt;
    logic           samp_a, samp_b;
    logic           vote;
    logic           dec;
    logic           bit_end;

    // Frame assembly
    logic [DATA_BITS-1:0] shreg;
    logic                 par_en_r, par_odd_r, two_stop_r;
    logic                 par_bit_r, perr_r, ferr_r;
    logic                 frame_zero;

    // FSM outputs
    logic frame_done;
    logic frame_ferr;
    logic brk_det;

    // Holding register handshake
    logic accept;
    logic load;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign div_eff    = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;
    assign tick       = (state != IDLE) && (div_cnt == div_lat - 1'b1);
    assign dec        = tick && (s_cnt == S_D);
    assign bit_end    = tick && (s_cnt == S_LAST);
    assign vote       = majority3(samp_a, samp_b, rxd_p1);
    assign frame_zero = (shreg == '0) && !par_bit_r;
    assign accept     = rx_valid && rx_ready;
    assign load       = frame_done && (!rx_valid || rx_ready);
    assign rx_busy    = (state != IDLE);

    // Two-flop synchroniser, idles high so reset cannot fake a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_p1 <= rxd_p0;
        end
    end

    // Sample-tick divider; held at 0 in IDLE so sampling aligns to the start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            div_lat <= DIV_WIDTH'(1);
        end else if (state == IDLE || tick) begin
            div_cnt <= '0;
            div_lat <= div_eff;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state and frame completion / break decisions
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_ferr = ferr_r;
        brk_det    = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_p1) state_nxt = START;
            end
            START: begin
                if (dec && vote)  state_nxt = IDLE;
                else if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == B_LAST) state_nxt = par_en_r ? PARITY : STOP1;
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP1;
            end
            STOP1: begin
                if (dec) begin
                    if (!vote && frame_zero) begin
                        brk_det   = 1'b1;
                        state_nxt = BREAK;
                    end else if (!two_stop_r) begin
                        // Finish at mid-bit to leave margin for the next start edge
                        frame_done = 1'b1;
                        frame_ferr = ~vote;
                        state_nxt  = IDLE;
                    end
                end else if (bit_end) begin
                    state_nxt = STOP2;
                end
            end
            STOP2: begin
                if (dec) begin
                    frame_done = 1'b1;
                    frame_ferr = ferr_r | ~vote;
                    state_nxt  = IDLE;
                end
            end
            BREAK: begin
                if (rxd_p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!rx_en) begin
            state_nxt  = IDLE;
            frame_done = 1'b0;
            brk_det    = 1'b0;
        end
    end

    // Sample counter, voting samples, frame options and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            s_cnt      <= '0;
            bit_cnt    <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            two_stop_r <= 1'b0;
            par_bit_r  <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
        end else if (state == IDLE) begin
            s_cnt   <= '0;
            bit_cnt <= '0;
            if (state_nxt == START) begin
                par_en_r   <= ^parity_mode;
                par_odd_r  <= (parity_mode == 2'b10);
                two_stop_r <= two_stop;
                par_bit_r  <= 1'b0;
                perr_r     <= 1'b0;
                ferr_r     <= 1'b0;
            end
        end else if (tick) begin
            s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            if (s_cnt == S_A) samp_a <= rxd_p1;
            if (s_cnt == S_B) samp_b <= rxd_p1;
            if (s_cnt == S_D) begin
                case (state)
                    PARITY: begin
                        par_bit_r <= vote;
                        perr_r    <= vote != (^shreg ^ par_odd_r);
                    end
                    STOP1:   ferr_r <= ~vote;
                    default: ;
                endcase
            end
            if (state == DATA && s_cnt == S_LAST)
                bit_cnt <= (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Data shift register, LSB first; cleared at each new start
    always_ff @(posedge clk) begin
        if (state == IDLE && state_nxt == START)
            shreg <= '0;
        else if (state == DATA && dec)
            shreg <= {vote, shreg[DATA_BITS-1:1]};
    end

    // Holding register with valid/ready handshake, overrun and break outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_perror  <= 1'b0;
            rx_ferror  <= 1'b0;
            rx_overrun <= 1'b0;
            rx_break   <= 1'b0;
        end else begin
            rx_break <= brk_det;
            if (load) begin
                rx_data   <= shreg;
                rx_perror <= perr_r;
                rx_ferror <= frame_ferr;
                rx_valid  <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            if (frame_done && !load) rx_overrun <= 1'b1;
            else if (accept)         rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scenarios for uart_rx_param at 8 data bits,
// 16x oversampling and baud_div=4 (64 clk per bit).
module tb_uart_rx_param;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int DW  = 16;
    localparam int BIT = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_en = 1'b1;
    logic          rxd = 1'b1;
    logic [DW-1:0] baud_div = 16'd4;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop = 1'b0;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_perror, rx_ferror, rx_overrun, rx_break, rx_busy;

    int n_cmp = 0;
    int n_err = 0;

    int         valid_total = 0;
    int         brk_total = 0;
    int         busy_total = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .DIV_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .rxd(rxd), .baud_div(baud_div),
        .parity_mode(parity_mode), .two_stop(two_stop), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_perror(rx_perror),
        .rx_ferror(rx_ferror), .rx_overrun(rx_overrun), .rx_break(rx_break),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    // Observe outputs on the falling edge: count valid/break/busy cycles
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                valid_total <= valid_total + 1;
                last_data   <= rx_data;
                last_perr   <= rx_perror;
                last_ferr   <= rx_ferror;
            end
            if (rx_break) brk_total  <= brk_total + 1;
            if (rx_busy)  busy_total <= busy_total + 1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit has_par, input logic par,
                              input bit has_s2, input logic s2);
        logic [7:0] v;
        v = d;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        if (has_par) send_bit(par);
        send_bit(1'b1);
        if (has_s2) send_bit(s2);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", rx_valid); end
        n_cmp++; if (rx_perror !== 1'b0) begin n_err++; $display("FAIL reset_perror got %b want 0", rx_perror); end
        n_cmp++; if (rx_ferror !== 1'b0) begin n_err++; $display("FAIL reset_ferror got %b want 0", rx_ferror); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", rx_overrun); end
        n_cmp++; if (rx_break !== 1'b0) begin n_err++; $display("FAIL reset_break got %b want 0", rx_break); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", rx_busy); end
        reset = 1'b0;
        idle(5);
    endtask

    task automatic test_8n1();
        int v0;
        v0 = valid_total;
        rx_ready = 1'b1;
        send_frame(8'hA5, 0, 1'b0, 0, 1'b0);
        idle(20);
        n_cmp++; if (valid_total - v0 !== 1) begin n_err++; $display("FAIL 8n1_valid_cycles got %0d want 1", valid_total - v0); end
        n_cmp++; if (last_data !== 8'hA5) begin n_err++; $display("FAIL 8n1_data got %h want a5", last_data); end
        n_cmp++; if (last_perr !== 1'b0) begin n_err++; $display("FAIL 8n1_perror got %b want 0", last_perr); end
        n_cmp++; if (last_ferr !== 1'b0) begin n_err++; $display("FAIL 8n1_ferror got %b want 0", last_ferr); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL 8n1_overrun got %b want 0", rx_overrun); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL 8n1_valid_after got %b want 0", rx_valid); end
    endtask

    task automatic test_parity();
        rx_ready = 1'b0;
        // 0x3C has four ones: even parity bit should be 0, so a sent 1 is an error
        parity_mode = 2'b01;
        idle(2);
        send_frame(8'h3C, 1, 1'b1, 0, 1'b0);
        idle(20);
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL even_valid got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL even_data got %h want 3c", rx_data); end
        n_cmp++; if (rx_perror !== 1'b1) begin n_err++; $display("FAIL even_perror got %b want 1", rx_perror); end
        n_cmp++; if (rx_ferror !== 1'b0) begin n_err++; $display("FAIL even_ferror got %b want 0", rx_ferror); end
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL even_accept got %b want 0", rx_valid); end
        // Odd parity expects 1 for 0x3C
        parity_mode = 2'b10;
        idle(2);
        send_frame(8'h3C, 1, 1'b1, 0, 1'b0);
        idle(20);
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL odd_valid got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h3C) begin n_err++; $display("FAIL odd_data got %h want 3c", rx_data); end
        n_cmp++; if (rx_perror !== 1'b0) begin n_err++; $display("FAIL odd_perror got %b want 0", rx_perror); end
        rx_ready = 1'b1;
        idle(1);
        parity_mode = 2'b00;
        idle(5);
    endtask

    task automatic test_glitch();
        int v0, b0;
        v0 = valid_total;
        b0 = busy_total;
        rxd = 1'b0;
        idle(12);
        rxd = 1'b1;
        idle(100);
        n_cmp++; if (busy_total - b0 <= 0) begin n_err++; $display("FAIL glitch_busy_seen got %0d want >0", busy_total - b0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_end got %b want 0", rx_busy); end
        n_cmp++; if (valid_total - v0 !== 0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", valid_total - v0); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        send_frame(8'h11, 0, 1'b0, 0, 1'b0);
        idle(20);
        send_frame(8'h22, 0, 1'b0, 0, 1'b0);
        idle(20);
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h11) begin n_err++; $display("FAIL ovr_data got %h want 11", rx_data); end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", rx_overrun); end
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_accept_valid got %b want 0", rx_valid); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL ovr_accept_flag got %b want 0", rx_overrun); end
        rx_ready = 1'b1;
        idle(5);
    endtask

    task automatic test_break();
        int v0, k0;
        v0 = valid_total;
        k0 = brk_total;
        rxd = 1'b0;
        idle(12 * BIT);
        rxd = 1'b1;
        idle(40);
        n_cmp++; if (brk_total - k0 !== 1) begin n_err++; $display("FAIL break_pulses got %0d want 1", brk_total - k0); end
        n_cmp++; if (valid_total - v0 !== 0) begin n_err++; $display("FAIL break_valid got %0d want 0", valid_total - v0); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL break_exit_busy got %b want 0", rx_busy); end
        n_cmp++; if (rx_ferror !== 1'b0) begin n_err++; $display("FAIL break_ferror got %b want 0", rx_ferror); end
        v0 = valid_total;
        send_frame(8'h5A, 0, 1'b0, 0, 1'b0);
        idle(20);
        n_cmp++; if (valid_total - v0 !== 1) begin n_err++; $display("FAIL post_break_valid got %0d want 1", valid_total - v0); end
        n_cmp++; if (last_data !== 8'h5A) begin n_err++; $display("FAIL post_break_data got %h want 5a", last_data); end
        n_cmp++; if (last_ferr !== 1'b0) begin n_err++; $display("FAIL post_break_ferror got %b want 0", last_ferr); end
    endtask

    task automatic test_enable_stop2_reset();
        int v0;
        logic [7:0] d;
        v0 = valid_total;
        rx_ready = 1'b1;
        d = 8'h77;
        // Drop the enable partway through data bit 4 and let the line finish
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rxd = d[4];
        idle(20);
        rx_en = 1'b0;
        idle(2);
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL en_drop_busy got %b want 0", rx_busy); end
        idle(BIT - 22);
        for (int i = 5; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        idle(20);
        rx_en = 1'b1;
        idle(100);
        n_cmp++; if (valid_total - v0 !== 0) begin n_err++; $display("FAIL en_drop_valid got %0d want 0", valid_total - v0); end
        // Two stop bits with the second one low: delivered with framing error
        rx_ready = 1'b0;
        two_stop = 1'b1;
        idle(2);
        send_frame(8'hC3, 0, 1'b0, 1, 1'b0);
        idle(150);
        two_stop = 1'b0;
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL stop2_valid got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'hC3) begin n_err++; $display("FAIL stop2_data got %h want c3", rx_data); end
        n_cmp++; if (rx_ferror !== 1'b1) begin n_err++; $display("FAIL stop2_ferror got %b want 1", rx_ferror); end
        n_cmp++; if (rx_perror !== 1'b0) begin n_err++; $display("FAIL stop2_perror got %b want 0", rx_perror); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL stop2_busy got %b want 0", rx_busy); end
        // Reset in the middle of a frame clears everything on the next edge
        rxd = 1'b0;
        idle(100);
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL midframe_busy got %b want 1", rx_busy); end
        reset = 1'b1;
        rxd = 1'b1;
        idle(1);
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rst2_data got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rst2_valid got %b want 0", rx_valid); end
        n_cmp++; if (rx_ferror !== 1'b0) begin n_err++; $display("FAIL rst2_ferror got %b want 0", rx_ferror); end
        n_cmp++; if (rx_perror !== 1'b0) begin n_err++; $display("FAIL rst2_perror got %b want 0", rx_perror); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_err++; $display("FAIL rst2_overrun got %b want 0", rx_overrun); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rst2_busy got %b want 0", rx_busy); end
        reset = 1'b0;
        idle(5);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_overrun();
        test_break();
        test_enable_stop2_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
